// File: rtl/fifo_1r1w_ctrl_if.sv
// Handshake and RAM-port bundle for fifo_1r1w_ctrl.
// The slave modport is the controller's view; master is the producer/consumer/RAM side.
interface fifo_1r1w_ctrl_if #(
    parameter int width_p = 8,
    parameter int depth_p = 32
);
    localparam int aw = $clog2(depth_p);

    logic               valid_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               valid_o;
    logic [width_p-1:0] data_o;
    logic               ready_i;
    logic [aw:0]        count_o;
    logic               afull_o;
    logic               ram_wr_valid_o;
    logic [width_p-1:0] ram_wr_data_o;
    logic [aw-1:0]      ram_wr_addr_o;
    logic               ram_rd_valid_o;
    logic [aw-1:0]      ram_rd_addr_o;
    logic [width_p-1:0] ram_rd_data_i;

    modport slave (
        input  valid_i, data_i, ready_i, ram_rd_data_i,
        output ready_o, valid_o, data_o, count_o, afull_o,
               ram_wr_valid_o, ram_wr_data_o, ram_wr_addr_o,
               ram_rd_valid_o, ram_rd_addr_o
    );

    modport master (
        output valid_i, data_i, ready_i, ram_rd_data_i,
        input  ready_o, valid_o, data_o, count_o, afull_o,
               ram_wr_valid_o, ram_wr_data_o, ram_wr_addr_o,
               ram_rd_valid_o, ram_rd_addr_o
    );
endinterface

// File: rtl/fifo_1r1w_ctrl.sv
// FIFO controller driving an external 1r1w async-read RAM.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module fifo_1r1w_ctrl #(
    parameter int width_p = 8,
    parameter int depth_p = 32,
    parameter int afull_p = depth_p - 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    fifo_1r1w_ctrl_if.slave  bus
);
    localparam int aw = $clog2(depth_p);
    typedef logic [aw:0] ptr_t;

    localparam ptr_t afull_c = ptr_t'(afull_p);

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);

    // No bypass in either direction: a full FIFO refuses push even with a concurrent pop,
    // and valid_o is gated by reset so stale pointers never expose RAM contents.
    assign bus.ready_o = ~full & reset_i;
    assign bus.valid_o = ~empty & reset_i;

    assign push = bus.valid_i & bus.ready_o;
    assign pop  = bus.valid_o & bus.ready_i;

    assign bus.ram_wr_valid_o = push;
    assign bus.ram_wr_addr_o  = wr_ptr[aw-1:0];
    assign bus.ram_wr_data_o  = bus.data_i;

    assign bus.ram_rd_valid_o = bus.valid_o;
    assign bus.ram_rd_addr_o  = rd_ptr[aw-1:0];
    assign bus.data_o         = bus.ram_rd_data_i;

    assign bus.count_o = wr_ptr - rd_ptr;
    assign bus.afull_o = (bus.count_o >= afull_c);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_1r1w_ctrl.sv
// Self-checking bench for fifo_1r1w_ctrl: queue reference model plus a behavioural RAM.
module tb_fifo_1r1w_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AFULL = DEPTH - 2;

    logic clk_i = 1'b0;
    logic reset_i = 1'b0;
    always #5 clk_i = ~clk_i;

    fifo_1r1w_ctrl_if #(.width_p(WIDTH), .depth_p(DEPTH)) bus ();

    fifo_1r1w_ctrl #(.width_p(WIDTH), .depth_p(DEPTH), .afull_p(AFULL)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk_i) if (bus.ram_wr_valid_o) mem[bus.ram_wr_addr_o] <= bus.ram_wr_data_o;
    assign bus.ram_rd_data_i = mem[bus.ram_rd_addr_o];

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] popped[$];
    int n_push = 0;
    int n_pop  = 0;
    int tests  = 0;
    int fails  = 0;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    // One clock: drive at negedge, check combinational outputs, update model at posedge.
    task automatic cyc(input logic rst, input logic v, input logic [WIDTH-1:0] d, input logic r);
        logic ep, eo;
        @(negedge clk_i);
        reset_i     = rst;
        bus.valid_i = v;
        bus.data_i  = d;
        bus.ready_i = r;
        #1;
        ep = 1'b0;
        eo = 1'b0;
        if (!rst) begin
            chk("rst_ready", 32'(bus.ready_o), 0);
            chk("rst_valid", 32'(bus.valid_o), 0);
            chk("rst_wr_valid", 32'(bus.ram_wr_valid_o), 0);
        end else begin
            ep = v && (q.size() < DEPTH);
            eo = r && (q.size() > 0);
            chk("ready", 32'(bus.ready_o), 32'(q.size() < DEPTH));
            chk("valid", 32'(bus.valid_o), 32'(q.size() > 0));
            chk("count", 32'(bus.count_o), 32'(q.size()));
            chk("afull", 32'(bus.afull_o), 32'(q.size() >= AFULL));
            chk("wr_valid", 32'(bus.ram_wr_valid_o), 32'(ep));
            chk("rd_valid", 32'(bus.ram_rd_valid_o), 32'(q.size() > 0));
            chk("rd_addr", 32'(bus.ram_rd_addr_o), 32'(n_pop % DEPTH));
            if (ep) begin
                chk("wr_addr", 32'(bus.ram_wr_addr_o), 32'(n_push % DEPTH));
                chk("wr_data", 32'(bus.ram_wr_data_o), 32'(d));
            end
            if (q.size() > 0) chk("data_o", 32'(bus.data_o), 32'(q[0]));
        end
        @(posedge clk_i);
        if (!rst) begin
            q.delete();
            n_push = 0;
            n_pop  = 0;
        end else begin
            if (eo) begin
                popped.push_back(q.pop_front());
                n_pop++;
            end
            if (ep) begin
                q.push_back(d);
                n_push++;
            end
        end
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hEE;

        // Reset, then first cycle out of reset must already accept.
        cyc(0, 0, 0, 0);
        cyc(0, 1, 8'h55, 1);
        cyc(1, 0, 0, 0);

        // Three pushes with consumer stalled; valid_o follows one cycle later.
        cyc(1, 1, 8'h11, 0);
        cyc(1, 1, 8'h22, 0);
        cyc(1, 1, 8'h33, 0);
        cyc(1, 0, 0, 0);
        chk("req039_count", 32'(bus.count_o), 3);
        chk("req039_data", 32'(bus.data_o), 32'h11);

        // Random traffic biased toward filling, then toward draining.
        for (int i = 0; i < 150; i++)
            cyc(1, $urandom_range(0, 99) < 80, WIDTH'($urandom), $urandom_range(0, 99) < 30);
        for (int i = 0; i < 150; i++)
            cyc(1, $urandom_range(0, 99) < 30, WIDTH'($urandom), $urandom_range(0, 99) < 80);

        // Fill to full, attempt overflow, then push+pop while full.
        cyc(0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, WIDTH'($urandom), 0);
        cyc(1, 1, 8'hFF, 0);
        chk("full_count", 32'(bus.count_o), 32'(DEPTH));
        cyc(1, 1, 8'hFE, 1);
        cyc(1, 0, 0, 0);
        chk("after_full_pop_count", 32'(bus.count_o), 32'(DEPTH - 1));
        chk("after_full_pop_ready", 32'(bus.ready_o), 1);

        // Push+pop at depth-1 must not become full.
        cyc(1, 1, 8'h77, 1);
        cyc(1, 0, 0, 0);
        chk("dm1_count", 32'(bus.count_o), 32'(DEPTH - 1));

        // Steady 1-in/1-out stream of 0..99 across several wraps.
        cyc(0, 0, 0, 0);
        popped.delete();
        cyc(1, 1, 8'd0, 0);
        for (int i = 1; i < 100; i++) cyc(1, 1, WIDTH'(i), 1);
        cyc(1, 0, 0, 1);
        chk("stream_len", 32'(popped.size()), 100);
        for (int i = 0; i < 100 && i < popped.size(); i++) chk("stream_order", 32'(popped[i]), 32'(i));

        // Reset with 5 entries held; stale RAM must not surface.
        for (int i = 0; i < 5; i++) cyc(1, 1, WIDTH'(8'hC0 + i), 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 1);
        chk("post_rst_count", 32'(bus.count_o), 0);
        chk("post_rst_valid", 32'(bus.valid_o), 0);
        cyc(1, 1, 8'hAB, 0);
        cyc(1, 0, 0, 0);
        chk("first_after_rst", 32'(bus.data_o), 32'hAB);
        cyc(1, 0, 0, 1);

        // Empty with consumer ready: no underflow.
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1);
        chk("underflow_count", 32'(bus.count_o), 0);
        cyc(1, 1, 8'h5A, 1);
        cyc(1, 0, 0, 0);
        chk("underflow_data", 32'(bus.data_o), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_1r1w_ctrl.md
FIFO_1R1W_CTRL -- requirements
Module: fifo_1r1w_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low.
REQ-002 SHALL take parameter width_p, default 8, data word width in bits.
REQ-003 SHALL take parameter depth_p, default 32, entry count; power of two, >= 2.
REQ-004 SHALL take parameter afull_p, default depth_p-2, almost-full threshold in entries.
REQ-005 clk_i  input  1  clock; all state changes on posedge.
REQ-006 reset_i  input  1  synchronous reset, active-low: 0 = reset.
REQ-007 valid_i  input  1  producer offers data_i.
REQ-008 data_i  input  width_p  push data.
REQ-009 ready_o  output  1  controller accepts push this cycle.
REQ-010 valid_o  output  1  data_o holds the oldest entry.
REQ-011 data_o  output  width_p  head-of-queue data.
REQ-012 ready_i  input  1  consumer takes data_o this cycle.
REQ-013 count_o  output  $clog2(depth_p)+1  current occupancy, 0..depth_p.
REQ-014 afull_o  output  1  count_o >= afull_p.
REQ-015 ram_wr_valid_o  output  1  write strobe to the 1r1w async-read RAM.
REQ-016 ram_wr_data_o  output  width_p  RAM write data.
REQ-017 ram_wr_addr_o  output  $clog2(depth_p)  RAM write address.
REQ-018 ram_rd_valid_o  output  1  RAM read enable.
REQ-019 ram_rd_addr_o  output  $clog2(depth_p)  RAM read address.
REQ-020 ram_rd_data_i  input  width_p  RAM combinational read data.

Function
REQ-021 push = valid_i & ready_o; pop = valid_o & ready_i; both evaluated in the same cycle.
REQ-022 wr_ptr and rd_ptr SHALL each be $clog2(depth_p)+1 bits; low bits index the RAM, MSB is the wrap flag.
REQ-023 Empty: wr_ptr == rd_ptr. Full: low bits equal, MSBs differ.
REQ-024 ready_o = ~full & reset_i; no bypass, so a full FIFO never accepts, even when pop is asserted in the same cycle.
REQ-025 valid_o = ~empty; no write-to-read bypass, so first-word latency is 1 cycle (push in cycle N, valid_o high in N+1).
REQ-026 ram_wr_valid_o = push; ram_wr_addr_o = wr_ptr low bits; ram_wr_data_o = data_i, all combinational.
REQ-027 ram_rd_addr_o = rd_ptr low bits; ram_rd_valid_o = valid_o; data_o = ram_rd_data_i, combinational.
REQ-028 On push, wr_ptr += 1 with modulo 2*depth_p wrap; on pop, rd_ptr += 1, same wrap.
REQ-029 count_o = wr_ptr - rd_ptr, modulo 2*depth_p; simultaneous push and pop leaves count_o unchanged.
REQ-030 Pop while empty is impossible because valid_o=0; ready_i SHALL be ignored.
REQ-031 Push while full is impossible because ready_o=0; valid_i and data_i SHALL be ignored, with no RAM write.
REQ-032 When depth_p-1 entries are held and push and pop coincide, the FIFO SHALL stay at depth_p-1 and not become full.
REQ-033 Wrap-around SHALL be transparent: data order is preserved across any number of pointer wraps.
REQ-034 afull_o SHALL be combinational from count_o.

Reset
REQ-035 With reset_i=0 at posedge: wr_ptr=0, rd_ptr=0.
REQ-036 Outputs during and after reset: valid_o=0, count_o=0, afull_o=0 (afull_p>0), ram_wr_valid_o=0, ready_o=0 while reset_i=0.
REQ-037 Reset mid-operation SHALL discard all entries; stale RAM contents SHALL never appear with valid_o=1.
REQ-038 ready_o SHALL rise in the first cycle with reset_i=1.

Verification
REQ-039 Reset then push 0x11, 0x22, 0x33 on consecutive cycles, ready_i=0 -> valid_o rises one cycle after 0x11 is pushed; count_o=3; data_o=0x11.
REQ-040 Fill 32 entries (depth_p=32) -> ready_o=0 and count_o=32; afull_o rises at count 30; a 33rd valid_i causes no RAM write.
REQ-041 Full FIFO, valid_i=1 and ready_i=1 together -> only the pop occurs; count_o=31; ready_o=1 next cycle.
REQ-042 Steady-state stream at 1 push + 1 pop per cycle for 100 words (incrementing 0..99) -> count_o constant; output sequence 0..99 with pointers wrapped 3+ times.
REQ-043 Hold 5 entries, drive reset_i=0 for one cycle -> count_o=0, valid_o=0; next push 0xAB is the first word out.
REQ-044 Empty FIFO, ready_i=1 held for 10 cycles -> rd_ptr unchanged, count_o=0, no underflow.
